// File: rtl/mem_xfer_ctrl_if.sv
// Command handshake plus data-memory / register-file control bundle for mem_xfer_ctrl.
interface mem_xfer_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_maddr;
  logic [3:0] cmd_reg;
  logic [3:0] cmd_len;
  logic       busy;
  logic       done;
  logic [7:0] D_addr;
  logic       D_W_en;
  logic       RF_W_en;
  logic [3:0] RF_W_addr;
  logic [3:0] RF_Ra_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_maddr, cmd_reg, cmd_len,
    input  cmd_ready, busy, done, D_addr, D_W_en, RF_W_en, RF_W_addr, RF_Ra_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_maddr, cmd_reg, cmd_len,
    output cmd_ready, busy, done, D_addr, D_W_en, RF_W_en, RF_W_addr, RF_Ra_addr
  );
endinterface

// File: rtl/mem_xfer_ctrl.sv
// Sequences memory<->register-file word transfers: LOAD takes 1+MEM_RD_LAT cycles/word, STORE 1.
// Define MEMXFER_BURST_EN to transfer cmd_len+1 words per command; otherwise one word.
module mem_xfer_ctrl #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_xfer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD_ADDR, LD_WAIT, LD_WR, ST_WR, DONE} state_t;

  // LD_WAIT occupies MEM_RD_LAT-1 cycles; the counter holds the remaining extra cycles.
  localparam logic [1:0] WAIT_INIT = 2'((MEM_RD_LAT > 1) ? MEM_RD_LAT - 2 : 0);

  state_t     state, state_nxt;
  logic [7:0] addr, addr_nxt;
  logic [3:0] rg, rg_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] wcnt, wcnt_nxt;
  logic [3:0] len_in;
  logic       last;

`ifdef MEMXFER_BURST_EN
  assign len_in = bus.cmd_len;
`else
  logic unused_len;
  assign len_in     = 4'd0;
  assign unused_len = ^bus.cmd_len;
`endif

  assign last = (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      rg    <= '0;
      cnt   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      rg    <= rg_nxt;
      cnt   <= cnt_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    rg_nxt         = rg;
    cnt_nxt        = cnt;
    wcnt_nxt       = wcnt;
    bus.cmd_ready  = 1'b0;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    bus.D_addr     = '0;
    bus.D_W_en     = 1'b0;
    bus.RF_W_en    = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_Ra_addr = '0;

    case (state)
      IDLE: begin
        bus.busy      = 1'b0;
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_nxt  = bus.cmd_maddr;
          rg_nxt    = bus.cmd_reg;
          cnt_nxt   = len_in;
          state_nxt = bus.cmd_op ? ST_WR : LD_ADDR;
        end
      end
      LD_ADDR: begin
        bus.D_addr = addr;
        if (MEM_RD_LAT > 1) begin
          state_nxt = LD_WAIT;
          wcnt_nxt  = WAIT_INIT;
        end else begin
          state_nxt = LD_WR;
        end
      end
      LD_WAIT: begin
        bus.D_addr = addr;
        if (wcnt == 2'd0) state_nxt = LD_WR;
        else              wcnt_nxt  = wcnt - 2'd1;
      end
      LD_WR: begin
        bus.D_addr    = addr;
        bus.RF_W_en   = 1'b1;
        bus.RF_W_addr = rg;
        if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = LD_ADDR;
          addr_nxt  = addr + 8'd1;
          rg_nxt    = rg + 4'd1;
          cnt_nxt   = cnt - 4'd1;
        end
      end
      ST_WR: begin
        bus.D_addr     = addr;
        bus.D_W_en     = 1'b1;
        bus.RF_Ra_addr = rg;
        if (last) begin
          state_nxt = DONE;
        end else begin
          addr_nxt = addr + 8'd1;
          rg_nxt   = rg + 4'd1;
          cnt_nxt  = cnt - 4'd1;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // The state register only clears at the edge, so outputs are forced quiet while reset is high.
    if (reset) begin
      bus.cmd_ready  = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      bus.D_addr     = '0;
      bus.D_W_en     = 1'b0;
      bus.RF_W_en    = 1'b0;
      bus.RF_W_addr  = '0;
      bus.RF_Ra_addr = '0;
    end
  end
endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl: a MEM_RD_LAT=1 instance with memory/register-file models and a MEM_RD_LAT=3 instance.
module tb_mem_xfer_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_xfer_ctrl_if bus1();
  mem_xfer_ctrl_if bus3();

  mem_xfer_ctrl #(.MEM_RD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_xfer_ctrl #(.MEM_RD_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Data memory (1-cycle registered read) and register file (async read) behind dut1.
  logic [15:0] mem [256];
  logic [15:0] rf  [16];
  logic [15:0] rd_q;
  always @(posedge clk) begin
    rd_q <= mem[bus1.D_addr];
    if (bus1.D_W_en)  mem[bus1.D_addr]   <= rf[bus1.RF_Ra_addr];
    if (bus1.RF_W_en) rf[bus1.RF_W_addr] <= rd_q;
  end

  int   dwen1_cnt = 0, done1_cnt = 0, wen3_cnt = 0, done3_cnt = 0;
  logic both_seen = 1'b0;
  always @(posedge clk) begin
    if (bus1.D_W_en)  dwen1_cnt <= dwen1_cnt + 1;
    if (bus1.done)    done1_cnt <= done1_cnt + 1;
    if (bus3.RF_W_en) wen3_cnt  <= wen3_cnt + 1;
    if (bus3.done)    done3_cnt <= done3_cnt + 1;
    if ((bus1.D_W_en && bus1.RF_W_en) || (bus3.D_W_en && bus3.RF_W_en)) both_seen <= 1'b1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue1(input logic op, input logic [7:0] ma, input logic [3:0] rg, input logic [3:0] len);
    bus1.cmd_valid = 1'b1;
    bus1.cmd_op    = op;
    bus1.cmd_maddr = ma;
    bus1.cmd_reg   = rg;
    bus1.cmd_len   = len;
    #1 chk("issue_ready", 32'(bus1.cmd_ready), 32'd1);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic        op;
    logic [7:0]  ma;
    logic [3:0]  rg;
    logic [15:0] data;
    int          exp_done;
  } vec_t;

  localparam int NV = 6;
  vec_t tv [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, dn0, first_wen, done_at;
    logic stable;
    logic [3:0] wa;
    logic [7:0] exp_a [3];
    logic [3:0] exp_r [3];

    tv[0] = '{1'b1, 8'h00, 4'h1, 16'hAAAA, 2};
    tv[1] = '{1'b0, 8'h0F, 4'hF, 16'h5555, 3};
    tv[2] = '{1'b1, 8'hFF, 4'hF, 16'h1234, 2};
    tv[3] = '{1'b0, 8'h80, 4'h0, 16'hBEEF, 3};
    tv[4] = '{1'b1, 8'h5A, 4'h7, 16'h0F0F, 2};
    tv[5] = '{1'b0, 8'hFF, 4'h3, 16'hC3C3, 3};

    reset = 1'b1;
    bus1.cmd_valid = 1'b1; bus1.cmd_op = 1'b0; bus1.cmd_maddr = 8'h00; bus1.cmd_reg = 4'h0; bus1.cmd_len = 4'h0;
    bus3.cmd_valid = 1'b0; bus3.cmd_op = 1'b0; bus3.cmd_maddr = 8'h00; bus3.cmd_reg = 4'h0; bus3.cmd_len = 4'h0;

    // Reset state, with a command pending that must not be taken.
    repeat (2) @(negedge clk);
    chk("rst_ready",  32'(bus1.cmd_ready),  32'd0);
    chk("rst_busy",   32'(bus1.busy),       32'd0);
    chk("rst_done",   32'(bus1.done),       32'd0);
    chk("rst_daddr",  32'(bus1.D_addr),     32'd0);
    chk("rst_dwen",   32'(bus1.D_W_en),     32'd0);
    chk("rst_rfwen",  32'(bus1.RF_W_en),    32'd0);
    chk("rst_rfwa",   32'(bus1.RF_W_addr),  32'd0);
    chk("rst_rfra",   32'(bus1.RF_Ra_addr), 32'd0);
    bus1.cmd_valid = 1'b0;
    reset = 1'b0;
    #1 chk("rst_release_ready", 32'(bus1.cmd_ready), 32'd1);
    @(negedge clk);

    // Single-word vectors.
    for (int i = 0; i < NV; i++) begin
      if (tv[i].op) rf[tv[i].rg] <= tv[i].data;
      else          mem[tv[i].ma] <= tv[i].data;
      @(negedge clk);
      issue1(tv[i].op, tv[i].ma, tv[i].rg, 4'h0);
      for (int k = 1; k <= tv[i].exp_done; k++) begin
        if (k < tv[i].exp_done) begin
          chk("vec_busy",  32'(bus1.busy),    32'd1);
          chk("vec_daddr", 32'(bus1.D_addr),  32'(tv[i].ma));
          chk("vec_dwen",  32'(bus1.D_W_en),  32'(tv[i].op));
          chk("vec_rfwen", 32'(bus1.RF_W_en), 32'(!tv[i].op && k == tv[i].exp_done - 1));
          if (!tv[i].op && k == tv[i].exp_done - 1) chk("vec_rfwa", 32'(bus1.RF_W_addr), 32'(tv[i].rg));
          if (tv[i].op) chk("vec_rfra", 32'(bus1.RF_Ra_addr), 32'(tv[i].rg));
        end else begin
          chk("vec_done",       32'(bus1.done),    32'd1);
          chk("vec_done_daddr", 32'(bus1.D_addr),  32'd0);
          chk("vec_done_wen",   32'(bus1.D_W_en | bus1.RF_W_en), 32'd0);
        end
        @(negedge clk);
      end
      chk("vec_idle_done",  32'(bus1.done),      32'd0);
      chk("vec_idle_busy",  32'(bus1.busy),      32'd0);
      chk("vec_idle_ready", 32'(bus1.cmd_ready), 32'd1);
      if (tv[i].op) chk("vec_mem", 32'(mem[tv[i].ma]), 32'(tv[i].data));
      else          chk("vec_rf",  32'(rf[tv[i].rg]),  32'(tv[i].data));
    end

    // MEM_RD_LAT=3: write-enable three edges after accept, address held throughout.
    bus3.cmd_valid = 1'b1; bus3.cmd_op = 1'b0; bus3.cmd_maddr = 8'h3C; bus3.cmd_reg = 4'h9;
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    first_wen = -1; done_at = -1; stable = 1'b1; wa = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      if (bus3.RF_W_en && first_wen < 0) begin first_wen = k; wa = bus3.RF_W_addr; end
      if (bus3.done && done_at < 0) done_at = k;
      if (done_at < 0 && bus3.D_addr !== 8'h3C) stable = 1'b0;
      @(negedge clk);
    end
    chk("lat3_wen_cycle",  32'(first_wen), 32'd4);
    chk("lat3_wen_addr",   32'(wa),        32'h9);
    chk("lat3_done_cycle", 32'(done_at),   32'd5);
    chk("lat3_addr_held",  32'(stable),    32'd1);

    // Reset while in LD_WAIT aborts the load.
    w0 = wen3_cnt; d0 = done3_cnt;
    bus3.cmd_valid = 1'b1; bus3.cmd_op = 1'b0; bus3.cmd_maddr = 8'h10; bus3.cmd_reg = 4'h5;
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait_busy", 32'(bus3.busy),    32'd1);
    chk("abort_in_wait_addr", 32'(bus3.D_addr),  32'h10);
    reset = 1'b1;
    #1 chk("abort_rst_busy",  32'(bus3.busy),      32'd0);
    chk("abort_rst_ready",    32'(bus3.cmd_ready), 32'd0);
    chk("abort_rst_daddr",    32'(bus3.D_addr),    32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_release_ready", 32'(bus3.cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("abort_no_rfwen", 32'(wen3_cnt - w0),  32'd0);
    chk("abort_no_done",  32'(done3_cnt - d0), 32'd0);

    // Second command held valid while busy is taken only after DONE.
    rf[2] <= 16'h7777; mem[8'h21] <= 16'h1111;
    @(negedge clk);
    d0 = dwen1_cnt; dn0 = done1_cnt;
    bus1.cmd_valid = 1'b1; bus1.cmd_op = 1'b1; bus1.cmd_maddr = 8'h20; bus1.cmd_reg = 4'h2; bus1.cmd_len = 4'h0;
    @(negedge clk);
    bus1.cmd_op = 1'b0; bus1.cmd_maddr = 8'h21; bus1.cmd_reg = 4'h3;
    chk("hold_k1_ready", 32'(bus1.cmd_ready), 32'd0);
    chk("hold_k1_daddr", 32'(bus1.D_addr),    32'h20);
    @(negedge clk);
    chk("hold_k2_done",  32'(bus1.done),      32'd1);
    chk("hold_k2_ready", 32'(bus1.cmd_ready), 32'd0);
    @(negedge clk);
    chk("hold_k3_ready", 32'(bus1.cmd_ready), 32'd1);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    chk("hold_k4_busy",  32'(bus1.busy),    32'd1);
    chk("hold_k4_daddr", 32'(bus1.D_addr),  32'h21);
    chk("hold_k4_dwen",  32'(bus1.D_W_en),  32'd0);
    repeat (3) @(negedge clk);
    chk("hold_store_cnt", 32'(dwen1_cnt - d0), 32'd1);
    chk("hold_done_cnt",  32'(done1_cnt - dn0), 32'd2);
    chk("hold_mem",       32'(mem[8'h20]),      32'h7777);
    chk("hold_rf",        32'(rf[3]),           32'h1111);

`ifdef MEMXFER_BURST_EN
    // Burst STORE across both address and register wrap.
    rf[4'hF] <= 16'hA1A1; rf[4'h0] <= 16'hB2B2; rf[4'h1] <= 16'hC3C3;
    @(negedge clk);
    dn0 = done1_cnt;
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    exp_r[0] = 4'hF;  exp_r[1] = 4'h0;  exp_r[2] = 4'h1;
    issue1(1'b1, 8'hFE, 4'hF, 4'd2);
    for (int k = 0; k < 3; k++) begin
      chk("burst_dwen",  32'(bus1.D_W_en),     32'd1);
      chk("burst_daddr", 32'(bus1.D_addr),     32'(exp_a[k]));
      chk("burst_rfra",  32'(bus1.RF_Ra_addr), 32'(exp_r[k]));
      chk("burst_ndone", 32'(bus1.done),       32'd0);
      @(negedge clk);
    end
    chk("burst_done", 32'(bus1.done), 32'd1);
    @(negedge clk);
    chk("burst_idle",     32'(bus1.busy),        32'd0);
    chk("burst_done_cnt", 32'(done1_cnt - dn0),  32'd1);
    chk("burst_mem0",     32'(mem[8'hFE]),       32'hA1A1);
    chk("burst_mem1",     32'(mem[8'hFF]),       32'hB2B2);
    chk("burst_mem2",     32'(mem[8'h00]),       32'hC3C3);
`else
    // Without bursts cmd_len is ignored: one word per command.
    rf[4] <= 16'h4444;
    @(negedge clk);
    d0 = dwen1_cnt;
    issue1(1'b1, 8'h40, 4'h4, 4'hF);
    chk("len_ign_dwen", 32'(bus1.D_W_en), 32'd1);
    @(negedge clk);
    chk("len_ign_done", 32'(bus1.done),   32'd1);
    chk("len_ign_stop", 32'(bus1.D_W_en), 32'd0);
    @(negedge clk);
    chk("len_ign_idle",  32'(bus1.busy),       32'd0);
    chk("len_ign_count", 32'(dwen1_cnt - d0),  32'd1);
    chk("len_ign_mem",   32'(mem[8'h40]),      32'h4444);
`endif

    chk("enables_exclusive", 32'(both_seen), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
